// File: rtl/ysyx_041461_if2_buf_pkg.sv
// Shared constants and the fetch payload type for the IF2 buffer stage.
package ysyx_041461_if2_buf_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned TRAP_W = 4;

    localparam logic [TRAP_W-1:0] TRAP_NOP         = 4'd0;
    localparam logic [TRAP_W-1:0] TRAP_IF_MULTIHIT = 4'd15;
    localparam logic [INST_W-1:0] INST_NOP         = 32'h0000_0013;

    // One queued fetch as presented to ID.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [TRAP_W-1:0] trap;
    } fetch_t;

    localparam int unsigned FETCH_W = $bits(fetch_t);

endpackage

// File: rtl/ysyx_041461_if2_buf_if.sv
// IF1 -> IF2 -> ID handshake and data bundle for the IF2 buffer stage.
interface ysyx_041461_if2_buf_if #(
    parameter int unsigned NWAY  = 8,
    parameter int unsigned WAY_W = 64,
    parameter int unsigned AXI_W = 64
);
    import ysyx_041461_if2_buf_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [PC_W-1:0]         in_pc;
    logic [NWAY-1:0]         in_hit;
    logic [TRAP_W-1:0]       in_trap;
    logic [NWAY*WAY_W-1:0]   sram_rdata;
    logic [AXI_W-1:0]        axi_rdata;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [PC_W-1:0]         out_pc;
    logic [INST_W-1:0]       out_inst;
    logic [TRAP_W-1:0]       out_trap;

    // Stage side
    modport slave (
        input  in_valid, in_pc, in_hit, in_trap, sram_rdata, axi_rdata, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_trap
    );

    // IF1 / ID side
    modport master (
        output in_valid, in_pc, in_hit, in_trap, sram_rdata, axi_rdata, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_trap
    );

endinterface

// File: rtl/ysyx_041461_if2_fifo.sv
// Generic synchronous FIFO with flush; storage cleared by async reset.
module ysyx_041461_if2_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer/count next state; flush wins over push and pop.
    always_comb begin
        do_push  = push_i & ~full_o & ~flush_i;
        do_pop   = pop_i & ~empty_o & ~flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ysyx_041461_if2_buf.sv
// IF2 stage: pick the fetched word from the hit way or AXI beat, merge traps, queue for ID.
module ysyx_041461_if2_buf
    import ysyx_041461_if2_buf_pkg::*;
#(
    parameter int unsigned NWAY  = 8,
    parameter int unsigned WAY_W = 64,
    parameter int unsigned AXI_W = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_041461_if2_buf_if.slave  bus
);

    logic [WAY_W-1:0]  way_slice_c;
    logic [INST_W-1:0] way_word_c;
    logic [INST_W-1:0] axi_word_c;
    logic              miss_c;
    logic              multihit_c;
    fetch_t            wr_entry_c;
    fetch_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_c;
    logic              pop_c;

    // OR-reduce the one-hot selected way slice out of the SRAM read data.
    always_comb begin
        way_slice_c = '0;
        for (int w = 0; w < int'(NWAY); w++) begin
            if (bus.in_hit[w]) way_slice_c = way_slice_c | bus.sram_rdata[w*WAY_W +: WAY_W];
        end
    end

    if (WAY_W == 32) begin : g_way_one_word
        assign way_word_c = way_slice_c;
    end else begin : g_way_word_sel
        localparam int unsigned WIDX_W = $clog2(WAY_W / 32);
        logic [WIDX_W-1:0] widx;
        assign widx       = bus.in_pc[WIDX_W+1:2];
        assign way_word_c = way_slice_c[32*widx +: 32];
    end

    if (AXI_W == 32) begin : g_axi_one_word
        assign axi_word_c = bus.axi_rdata;
    end else begin : g_axi_word_sel
        localparam int unsigned AIDX_W = $clog2(AXI_W / 32);
        logic [AIDX_W-1:0] aidx;
        assign aidx       = bus.in_pc[AIDX_W+1:2];
        assign axi_word_c = bus.axi_rdata[32*aidx +: 32];
    end

    assign miss_c     = (bus.in_hit == '0);
    assign multihit_c = ((bus.in_hit & (bus.in_hit - NWAY'(1))) != '0);

    // Trap merge: IF1 trap first, then multi-way hit, else the extracted word.
    always_comb begin
        wr_entry_c.pc   = bus.in_pc;
        wr_entry_c.inst = miss_c ? axi_word_c : way_word_c;
        wr_entry_c.trap = TRAP_NOP;
        if (bus.in_trap != TRAP_NOP) begin
            wr_entry_c.inst = INST_NOP;
            wr_entry_c.trap = bus.in_trap;
        end else if (multihit_c) begin
            wr_entry_c.inst = INST_NOP;
            wr_entry_c.trap = TRAP_IF_MULTIHIT;
        end
    end

    // Handshakes: ready from registered fullness; flush masks output and drops input.
    assign bus.in_ready  = ~fifo_full | bus.flush;
    assign bus.out_valid = ~fifo_empty & ~bus.flush;
    assign push_c        = bus.in_valid & bus.in_ready;
    assign pop_c         = bus.out_valid & bus.out_ready;

    ysyx_041461_if2_fifo #(
        .DEPTH (DEPTH),
        .W     (FETCH_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.flush),
        .push_i  (push_c),
        .wdata_i (wr_entry_c),
        .pop_i   (pop_c),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.out_pc   = head.pc;
    assign bus.out_inst = head.inst;
    assign bus.out_trap = head.trap;

endmodule

// File: tb/tb_ysyx_041461_if2_buf.sv
// Randomized + directed bench for ysyx_041461_if2_buf against a queue-based model.
module tb_ysyx_041461_if2_buf;
    import ysyx_041461_if2_buf_pkg::*;

    localparam int unsigned NWAY  = 8;
    localparam int unsigned WAY_W = 64;
    localparam int unsigned AXI_W = 64;
    localparam int unsigned DEPTH = 2;

    logic clk;
    logic rst_n;

    ysyx_041461_if2_buf_if #(.NWAY(NWAY), .WAY_W(WAY_W), .AXI_W(AXI_W)) bus ();

    ysyx_041461_if2_buf #(.NWAY(NWAY), .WAY_W(WAY_W), .AXI_W(AXI_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus variables applied by tick()
    logic        v, fl, ordy;
    logic [63:0] pc;
    logic [7:0]  hit;
    logic [3:0]  trap;
    logic [63:0] ways [NWAY];
    logic [63:0] axi;

    fetch_t      q [$];
    logic [63:0] popped [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected queue entry from the stage's rules.
    function automatic fetch_t model(input logic [63:0] p, input logic [7:0] h, input logic [3:0] t);
        fetch_t      e;
        logic [63:0] line;
        e.pc = p;
        line = axi;
        if (t != 4'd0) begin
            e.inst = 32'h0000_0013;
            e.trap = t;
        end else if ($countones(h) > 1) begin
            e.inst = 32'h0000_0013;
            e.trap = 4'd15;
        end else begin
            for (int i = 0; i < int'(NWAY); i++) if (h[i]) line = ways[i];
            e.inst = p[2] ? line[63:32] : line[31:0];
            e.trap = 4'd0;
        end
        return e;
    endfunction

    task automatic apply();
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_hit    = hit;
        bus.in_trap   = trap;
        bus.axi_rdata = axi;
        bus.flush     = fl;
        bus.out_ready = ordy;
        for (int w = 0; w < int'(NWAY); w++) bus.sram_rdata[w*WAY_W +: WAY_W] = ways[w];
    endtask

    // One cycle: drive, compare against the model, advance the model across the edge.
    task automatic tick();
        logic   exp_rdy, exp_ov;
        bit     do_pop, do_push;
        fetch_t e;
        apply();
        #1;
        exp_rdy = (q.size() < DEPTH) || fl;
        exp_ov  = (q.size() != 0) && !fl;
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            check("out_pc", bus.out_pc, q[0].pc);
            check("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
            check("out_trap", 64'(bus.out_trap), 64'(q[0].trap));
        end
        do_pop  = exp_ov && ordy;
        do_push = v && !fl && (q.size() < DEPTH);
        if (do_pop) popped.push_back(bus.out_pc);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e = model(pc, hit, trap);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pop();
        v = 1'b0; fl = 1'b0; ordy = 1'b1; trap = 4'd0; hit = 8'd0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        v = 1'b0; fl = 1'b0; ordy = 1'b0; pc = '0; hit = '0; trap = '0; axi = '0;
        for (int w = 0; w < int'(NWAY); w++) ways[w] = '0;
        apply();
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_pc", bus.out_pc, 64'd0);
        check("rst_out_inst", 64'(bus.out_inst), 64'd0);
        check("rst_out_trap", 64'(bus.out_trap), 64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hit on way 2, upper word
        for (int w = 0; w < int'(NWAY); w++) ways[w] = {$urandom, $urandom};
        ways[2] = 64'hAAAA0001_BBBB0002;
        v = 1'b1; pc = 64'h8000_0004; hit = 8'b0000_0100; trap = 4'd0; ordy = 1'b0;
        tick();
        check("hit_hi_inst", 64'(bus.out_inst), 64'h0000_0000_AAAA0001);
        check("hit_hi_trap", 64'(bus.out_trap), 64'd0);
        idle_pop();

        // Same hit, lower word
        v = 1'b1; pc = 64'h8000_0000; hit = 8'b0000_0100; ordy = 1'b0;
        tick();
        check("hit_lo_inst", 64'(bus.out_inst), 64'h0000_0000_BBBB0002);
        idle_pop();

        // Miss takes the AXI beat
        axi = 64'h11111111_22222222;
        v = 1'b1; pc = 64'h8000_0004; hit = 8'd0; ordy = 1'b0;
        tick();
        check("miss_inst", 64'(bus.out_inst), 64'h0000_0000_11111111);
        idle_pop();

        // IF1 trap passes through with a NOP
        v = 1'b1; pc = 64'h8000_0008; hit = 8'b0000_0100; trap = 4'd3; ordy = 1'b0;
        tick();
        check("trap_code", 64'(bus.out_trap), 64'd3);
        check("trap_inst", 64'(bus.out_inst), 64'h13);
        idle_pop();

        // Multi-way hit
        v = 1'b1; pc = 64'h8000_000c; hit = 8'b0001_0001; trap = 4'd0; ordy = 1'b0;
        tick();
        check("multihit_trap", 64'(bus.out_trap), 64'd15);
        check("multihit_inst", 64'(bus.out_inst), 64'h13);
        idle_pop();

        // Back-pressure: A, B accepted, C held off until space frees
        popped.delete();
        hit = 8'b0000_0001; trap = 4'd0; ordy = 1'b0; v = 1'b1;
        pc = 64'hA0; tick();
        pc = 64'hB0; tick();
        pc = 64'hC0;
        check("bp_full_ready", 64'(bus.in_ready), 64'd0);
        tick();
        ordy = 1'b1;
        tick();
        tick();
        v = 1'b0;
        tick();
        tick();
        check("bp_pop_count", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            check("bp_pop_a", popped[0], 64'hA0);
            check("bp_pop_b", popped[1], 64'hB0);
            check("bp_pop_c", popped[2], 64'hC0);
        end

        // Flush with two queued and a fetch incoming
        ordy = 1'b0; v = 1'b1;
        pc = 64'h100; tick();
        pc = 64'h104; tick();
        pc = 64'h108; fl = 1'b1;
        apply();
        #1;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        fl = 1'b0; v = 1'b0;
        apply();
        #1;
        check("post_flush_empty", 64'(bus.out_valid), 64'd0);
        tick();

        // Asynchronous reset with the FIFO full
        v = 1'b1; ordy = 1'b0;
        pc = 64'h200; tick();
        pc = 64'h204; tick();
        v = 1'b0;
        apply();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        #1 rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 60);
            fl   = ($urandom_range(0, 99) < 5);
            pc   = {$urandom, $urandom};
            axi  = {$urandom, $urandom};
            for (int w = 0; w < int'(NWAY); w++) ways[w] = {$urandom, $urandom};
            r = $urandom_range(0, 99);
            if (r < 60)      hit = 8'd1 << $urandom_range(0, 7);
            else if (r < 85) hit = 8'd0;
            else             hit = 8'($urandom);
            trap = ($urandom_range(0, 99) < 10) ? 4'($urandom) : 4'd0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
